// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
//   state_t : arbiter FSM states (IDLE, RD_WAIT)
//   owner_t : which port owns the outstanding read (OWN_F fetch, OWN_D data)
package mem_arb_pkg;

    localparam int unsigned AW_DEF       = 16;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned LATENCY_DEF  = 1;
    localparam int unsigned MAX_WAIT_DEF = 3;
    localparam int unsigned PERF_W       = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch port (F) and the
// load/store port (D). Data wins by default; fetch is forced through after MAX_WAIT
// consecutive losses. One read outstanding at a time, returned LATENCY cycles after grant.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   f_req/f_addr -> f_gnt              fetch request / combinational grant
//   f_rvalid/f_rdata                   fetch read return (pulse) / held data
//   d_req/d_we/d_addr/d_wdata -> d_gnt data request / combinational grant
//   d_rvalid/d_rdata                   load return (pulse) / held data
//   mem_en/mem_we/mem_addr/mem_wdata   memory command, driven in the grant cycle
//   mem_rdata                          memory read data
//   stall_if/stall_ex                  requester pending and not granted
// Optional: define MEM_ARB_PERF_EN to add perf_conflict / perf_starve counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned LATENCY  = LATENCY_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_ex
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_conflict,
    output logic [PERF_W-1:0] perf_starve
`endif
);

    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam int unsigned SW = $clog2(MAX_WAIT + 1);

    state_t          r_state;
    owner_t          r_owner;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_starve;
    logic [DW-1:0]   r_f_rdata;
    logic [DW-1:0]   r_d_rdata;

    logic w_last;
    logic w_slot;
    logic w_force;
    logic w_f_gnt;
    logic w_d_gnt;
    logic w_rd_gnt;
    logic w_f_ret;
    logic w_d_ret;

    // Last RD_WAIT cycle: read data is on mem_rdata and a new grant may issue.
    assign w_last   = (r_state == RD_WAIT) && (r_cnt == '0);
    // Grants are suppressed while reset is asserted even though the FSM already reads IDLE.
    assign w_slot   = reset_n && ((r_state == IDLE) || w_last);
    assign w_force  = f_req && (r_starve == SW'(MAX_WAIT));
    assign w_d_gnt  = w_slot && d_req && !w_force;
    assign w_f_gnt  = w_slot && f_req && !w_d_gnt;
    assign w_rd_gnt = w_f_gnt || (w_d_gnt && !d_we);
    assign w_f_ret  = w_last && (r_owner == OWN_F);
    assign w_d_ret  = w_last && (r_owner == OWN_D);

    assign f_gnt     = w_f_gnt;
    assign d_gnt     = w_d_gnt;
    assign stall_if  = f_req && !w_f_gnt;
    assign stall_ex  = d_req && !w_d_gnt;
    assign mem_en    = w_f_gnt || w_d_gnt;
    assign mem_we    = w_d_gnt && d_we;
    assign mem_addr  = w_d_gnt ? d_addr : (w_f_gnt ? f_addr : '0);
    assign mem_wdata = (w_d_gnt && d_we) ? d_wdata : '0;

    // Returned data is forwarded in its valid cycle and held in the register afterwards.
    assign f_rvalid = w_f_ret;
    assign d_rvalid = w_d_ret;
    assign f_rdata  = w_f_ret ? mem_rdata : r_f_rdata;
    assign d_rdata  = w_d_ret ? mem_rdata : r_d_rdata;

    // FSM, latency countdown, read owner, starvation counter and held read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_owner   <= OWN_F;
            r_cnt     <= '0;
            r_starve  <= '0;
            r_f_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_f_ret) r_f_rdata <= mem_rdata;
            if (w_d_ret) r_d_rdata <= mem_rdata;

            if (w_rd_gnt) begin
                r_state <= RD_WAIT;
                r_cnt   <= CW'(LATENCY - 1);
                r_owner <= w_f_gnt ? OWN_F : OWN_D;
            end else if (w_last) begin
                r_state <= IDLE;
            end else if (r_state == RD_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_f_gnt || !f_req) begin
                r_starve <= '0;
            end else if (w_d_gnt && (r_starve != SW'(MAX_WAIT))) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [PERF_W-1:0] r_perf_conflict;
    logic [PERF_W-1:0] r_perf_starve;
    logic              w_conflict;
    logic              w_forced;

    // With both requesting, at most one can win, so every such cycle denies someone.
    assign w_conflict = f_req && d_req;
    assign w_forced   = w_f_gnt && w_force && d_req;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_conflict <= '0;
            r_perf_starve   <= '0;
        end else begin
            if (w_conflict && (r_perf_conflict != '1)) r_perf_conflict <= r_perf_conflict + PERF_W'(1);
            if (w_forced && (r_perf_starve != '1))     r_perf_starve   <= r_perf_starve + PERF_W'(1);
        end
    end

    assign perf_conflict = r_perf_conflict;
    assign perf_starve   = r_perf_starve;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table (LATENCY=1), randomized run against a
// transaction-level model (LATENCY=1), and directed latency/reset sequences (LATENCY=3).
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- LATENCY=1 instance ----------------
    logic        reset_n, f_req, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if, stall_ex;
    logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] pc1, ps1, pc3, ps3;
`endif

    mem_port_arbiter #(.AW(16), .DW(16), .LATENCY(1), .MAX_WAIT(3)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_ex(stall_ex)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflict(pc1), .perf_starve(ps1)
`endif
    );

    // Synchronous memory, one-cycle read latency; contents start at 0x1000+addr.
    logic [15:0] mem1 [256];
    logic        mem1_init = 1'b0;
    logic [15:0] rd1 = 16'h0;
    always @(posedge clk) begin
        if (!mem1_init) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 16'h1000 + 16'(i);
            mem1_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
            else        rd1 <= mem1[mem_addr[7:0]];
        end
    end
    assign mem_rdata = rd1;

    // ---------------- LATENCY=3 instance ----------------
    logic        rst3_n, f_req3, d_req3, d_we3;
    logic [15:0] f_addr3, d_addr3, d_wdata3;
    logic        f_gnt3, f_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, stall_if3, stall_ex3;
    logic [15:0] f_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    mem_port_arbiter #(.AW(16), .DW(16), .LATENCY(3), .MAX_WAIT(3)) u_dut3 (
        .clk(clk), .reset_n(rst3_n),
        .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3), .f_rdata(f_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .stall_if(stall_if3), .stall_ex(stall_ex3)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflict(pc3), .perf_starve(ps3)
`endif
    );

    // Read-only memory with three-cycle latency, contents 0x1000+addr.
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        if (mem_en3 && !mem_we3) p3[0] <= 16'h1000 + mem_addr3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata3 = p3[2];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        fr;
        logic [15:0] fa;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dd;
        logic        efg, edg, efv, edv;
        logic [15:0] efrd, edrd;
    } vec_t;

    function automatic vec_t v(input logic fr, input logic [15:0] fa, input logic dr, input logic dw,
                               input logic [15:0] da, input logic [15:0] dd,
                               input logic efg, input logic edg, input logic efv, input logic edv,
                               input logic [15:0] efrd, input logic [15:0] edrd);
        vec_t r;
        r.fr = fr; r.fa = fa; r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
        r.efg = efg; r.edg = edg; r.efv = efv; r.edv = edv; r.efrd = efrd; r.edrd = edrd;
        return r;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    logic [15:0] ref_mem [256];
    bit          pv;        // read outstanding
    int          pdue;      // cycle index at which it returns
    bit          pf;        // returns to fetch
    logic [15:0] pdata;
    int          starve;
    logic        m_fg, m_dg;
    logic [15:0] exp_frd, exp_drd;
    int          t;

    task automatic model_step();
        logic slot, frc, efv, edv;
        logic [15:0] ea, ew;
        efv = 1'b0; edv = 1'b0; m_fg = 1'b0; m_dg = 1'b0;
        if (!reset_n) begin
            pv = 1'b0; starve = 0; exp_frd = 16'h0; exp_drd = 16'h0;
        end else begin
            slot = !pv || (pdue == t);
            frc  = f_req && (starve >= 3);
            m_dg = slot && d_req && !frc;
            m_fg = slot && f_req && !m_dg;
            efv  = pv && (pdue == t) && pf;
            edv  = pv && (pdue == t) && !pf;
            if (efv) exp_frd = pdata;
            if (edv) exp_drd = pdata;
        end
        ea = m_dg ? d_addr : (m_fg ? f_addr : 16'h0);
        ew = (m_dg && d_we) ? d_wdata : 16'h0;
        chk($sformatf("rnd%0d f_gnt", t), 32'(f_gnt), 32'(m_fg));
        chk($sformatf("rnd%0d d_gnt", t), 32'(d_gnt), 32'(m_dg));
        chk($sformatf("rnd%0d f_rvalid", t), 32'(f_rvalid), 32'(efv));
        chk($sformatf("rnd%0d d_rvalid", t), 32'(d_rvalid), 32'(edv));
        chk($sformatf("rnd%0d f_rdata", t), 32'(f_rdata), 32'(exp_frd));
        chk($sformatf("rnd%0d d_rdata", t), 32'(d_rdata), 32'(exp_drd));
        chk($sformatf("rnd%0d stall_if", t), 32'(stall_if), 32'(f_req && !m_fg));
        chk($sformatf("rnd%0d stall_ex", t), 32'(stall_ex), 32'(d_req && !m_dg));
        chk($sformatf("rnd%0d mem_en", t), 32'(mem_en), 32'(m_fg || m_dg));
        chk($sformatf("rnd%0d mem_we", t), 32'(mem_we), 32'(m_dg && d_we));
        chk($sformatf("rnd%0d mem_addr", t), 32'(mem_addr), 32'(ea));
        chk($sformatf("rnd%0d mem_wdata", t), 32'(mem_wdata), 32'(ew));
        if (reset_n) begin
            if (pv && (pdue == t)) pv = 1'b0;
            if (m_fg) begin
                pv = 1'b1; pdue = t + 1; pf = 1'b1; pdata = ref_mem[f_addr[7:0]];
            end
            if (m_dg) begin
                if (d_we) ref_mem[d_addr[7:0]] = d_wdata;
                else begin
                    pv = 1'b1; pdue = t + 1; pf = 1'b0; pdata = ref_mem[d_addr[7:0]];
                end
            end
            if (m_fg || !f_req)           starve = 0;
            else if (m_dg && starve < 3)  starve++;
        end
        t++;
    endtask

    vec_t tab [18];

    initial begin
        tab[0]  = v(1, 16'h0, 0, 0, 16'h0,  16'h0,    1, 0, 0, 0, 16'h0,    16'h0);
        tab[1]  = v(1, 16'h1, 0, 0, 16'h0,  16'h0,    1, 0, 1, 0, 16'h1000, 16'h0);
        tab[2]  = v(1, 16'h2, 0, 0, 16'h0,  16'h0,    1, 0, 1, 0, 16'h1001, 16'h0);
        tab[3]  = v(0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 1, 0, 16'h1002, 16'h0);
        tab[4]  = v(0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 0, 0, 16'h1002, 16'h0);
        tab[5]  = v(1, 16'h3, 1, 0, 16'h10, 16'h0,    0, 1, 0, 0, 16'h1002, 16'h0);
        tab[6]  = v(1, 16'h3, 0, 0, 16'h0,  16'h0,    1, 0, 0, 1, 16'h1002, 16'h1010);
        tab[7]  = v(0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 1, 0, 16'h1003, 16'h1010);
        tab[8]  = v(1, 16'h4, 1, 1, 16'h20, 16'hBEEF, 0, 1, 0, 0, 16'h1003, 16'h1010);
        tab[9]  = v(1, 16'h4, 1, 1, 16'h20, 16'hBEEF, 0, 1, 0, 0, 16'h1003, 16'h1010);
        tab[10] = v(1, 16'h4, 1, 1, 16'h20, 16'hBEEF, 0, 1, 0, 0, 16'h1003, 16'h1010);
        tab[11] = v(1, 16'h4, 1, 1, 16'h20, 16'hBEEF, 1, 0, 0, 0, 16'h1003, 16'h1010);
        tab[12] = v(0, 16'h0, 1, 1, 16'h20, 16'hBEEF, 0, 1, 1, 0, 16'h1004, 16'h1010);
        tab[13] = v(0, 16'h0, 1, 1, 16'h5,  16'h00AA, 0, 1, 0, 0, 16'h1004, 16'h1010);
        tab[14] = v(0, 16'h0, 1, 0, 16'h5,  16'h0,    0, 1, 0, 0, 16'h1004, 16'h1010);
        tab[15] = v(0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 0, 1, 16'h1004, 16'h00AA);
        tab[16] = v(0, 16'h0, 1, 0, 16'h20, 16'h0,    0, 1, 0, 0, 16'h1004, 16'h00AA);
        tab[17] = v(0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 0, 1, 16'h1004, 16'hBEEF);

        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h1000 + 16'(i);
        reset_n = 1'b0; rst3_n = 1'b0;
        f_req = 1'b1; f_addr = 16'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        f_req3 = 1'b0; f_addr3 = 16'h0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = 16'h0; d_wdata3 = 16'h0;

        // Reset held with a pending fetch: nothing may be granted or returned.
        cyc(); cyc(); smp();
        chk("rst f_gnt", 32'(f_gnt), 32'h0);
        chk("rst d_gnt", 32'(d_gnt), 32'h0);
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst f_rvalid", 32'(f_rvalid), 32'h0);
        chk("rst d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst f_rdata", 32'(f_rdata), 32'h0);
        chk("rst d_rdata", 32'(d_rdata), 32'h0);

        // Directed table; row 0 is the first cycle after reset release.
        for (int i = 0; i < 18; i++) begin
            cyc();
            if (i == 0) reset_n = 1'b1;
            f_req = tab[i].fr; f_addr = tab[i].fa; d_req = tab[i].dr; d_we = tab[i].dw;
            d_addr = tab[i].da; d_wdata = tab[i].dd;
            smp();
            chk($sformatf("row%0d f_gnt", i), 32'(f_gnt), 32'(tab[i].efg));
            chk($sformatf("row%0d d_gnt", i), 32'(d_gnt), 32'(tab[i].edg));
            chk($sformatf("row%0d f_rvalid", i), 32'(f_rvalid), 32'(tab[i].efv));
            chk($sformatf("row%0d d_rvalid", i), 32'(d_rvalid), 32'(tab[i].edv));
            chk($sformatf("row%0d f_rdata", i), 32'(f_rdata), 32'(tab[i].efrd));
            chk($sformatf("row%0d d_rdata", i), 32'(d_rdata), 32'(tab[i].edrd));
            chk($sformatf("row%0d stall_if", i), 32'(stall_if), 32'(tab[i].fr && !tab[i].efg));
            chk($sformatf("row%0d stall_ex", i), 32'(stall_ex), 32'(tab[i].dr && !tab[i].edg));
            chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(tab[i].efg || tab[i].edg));
            chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tab[i].edg && tab[i].dw));
`ifdef MEM_ARB_PERF_EN
            if (i == 12) begin
                chk("perf_starve", 32'(ps1), 32'h1);
                chk("perf_conflict", 32'(pc1), 32'h5);
            end
`endif
        end
        ref_mem[8'h05] = 16'h00AA;
        ref_mem[8'h20] = 16'hBEEF;

        // Randomized run against the model, with occasional asynchronous resets.
        cyc(); reset_n = 1'b0; f_req = 1'b0; d_req = 1'b0;
        smp(); model_step();
        m_fg = 1'b0; m_dg = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(99) == 0) reset_n = 1'b0;
            if (!(f_req && !m_fg && $urandom_range(19) != 0)) begin
                f_req  = ($urandom_range(9) < 7);
                f_addr = 16'($urandom);
            end
            if (!(d_req && !m_dg && $urandom_range(19) != 0)) begin
                d_req   = ($urandom_range(9) < 6);
                d_we    = 1'($urandom_range(1));
                d_addr  = 16'($urandom_range(31));
                d_wdata = 16'($urandom);
            end
            smp();
            model_step();
        end

        // LATENCY=3: return timing, no grant while a read is in flight.
        f_req = 1'b0; d_req = 1'b0;
        cyc(); rst3_n = 1'b1;
        cyc(); d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 16'h10;
        smp(); chk("l3 gnt A", 32'(d_gnt3), 32'h1);
        chk("l3 mem_en A", 32'(mem_en3), 32'h1);
        cyc(); d_addr3 = 16'h11;
        smp(); chk("l3 gnt A+1", 32'(d_gnt3), 32'h0);
        chk("l3 stall A+1", 32'(stall_ex3), 32'h1);
        chk("l3 rv A+1", 32'(d_rvalid3), 32'h0);
        cyc();
        smp(); chk("l3 gnt A+2", 32'(d_gnt3), 32'h0);
        chk("l3 rv A+2", 32'(d_rvalid3), 32'h0);
        cyc();
        smp(); chk("l3 rv A+3", 32'(d_rvalid3), 32'h1);
        chk("l3 rdata A+3", 32'(d_rdata3), 32'h1010);
        chk("l3 gnt A+3", 32'(d_gnt3), 32'h1);
        cyc(); d_req3 = 1'b0;
        smp(); chk("l3 rv A+4", 32'(d_rvalid3), 32'h0);
        chk("l3 hold A+4", 32'(d_rdata3), 32'h1010);
        cyc();
        smp(); chk("l3 rv A+5", 32'(d_rvalid3), 32'h0);
        cyc();
        smp(); chk("l3 rv A+6", 32'(d_rvalid3), 32'h1);
        chk("l3 rdata A+6", 32'(d_rdata3), 32'h1011);

        // LATENCY=3: reset one cycle after a load grant discards the read.
        cyc(); d_req3 = 1'b1; d_addr3 = 16'h12;
        smp(); chk("l3 gnt B", 32'(d_gnt3), 32'h1);
        cyc(); d_req3 = 1'b0; rst3_n = 1'b0;
        smp(); chk("l3 rst rv", 32'(d_rvalid3), 32'h0);
        chk("l3 rst rdata", 32'(d_rdata3), 32'h0);
        for (int k = 2; k < 4; k++) begin
            cyc(); rst3_n = 1'b1;
            smp(); chk($sformatf("l3 B+%0d rv", k), 32'(d_rvalid3), 32'h0);
            chk($sformatf("l3 B+%0d rdata", k), 32'(d_rdata3), 32'h0);
        end
        cyc(); d_req3 = 1'b1; d_addr3 = 16'h13;
        smp(); chk("l3 idle gnt", 32'(d_gnt3), 32'h1);
        cyc(); d_req3 = 1'b0;
        smp(); chk("l3 C+1 rv", 32'(d_rvalid3), 32'h0);
        cyc();
        smp(); chk("l3 C+2 rv", 32'(d_rvalid3), 32'h0);
        cyc();
        smp(); chk("l3 C+3 rv", 32'(d_rvalid3), 32'h1);
        chk("l3 C+3 rdata", 32'(d_rdata3), 32'h1013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
